// File: rtl/ijtc_write_scheduler_pkg.sv
// ijtc_write_scheduler_pkg
//   Shared definitions for the IJTC table write scheduler:
//   default index/GHR/data widths, the scheduler FSM state encoding, and
//   the index hash macro IJTC_HASH(vaddr, ghr, w) = vaddr[w+1:2] ^ ghr.
//   Optional feature macro used by the slice: IJTC_WR_BYPASS_EN.
`ifndef IJTC_WRITE_SCHEDULER_PKG_SV
`define IJTC_WRITE_SCHEDULER_PKG_SV

// Word-aligned PC bits folded with the history register.
`define IJTC_HASH(vaddr, ghr, w) (((vaddr[(w)+1:2])) ^ (ghr))

package ijtc_write_scheduler_pkg;
  localparam int IJTC_IDX_W  = 10;
  localparam int IJTC_GHR_W  = 10;
  localparam int IJTC_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // queue empty, lookups own the table
    ST_DRAIN = 2'd1,  // queue non-empty, writes take idle lookup slots
    ST_FORCE = 2'd2   // starvation/full guard, lookups stalled one cycle
  } sched_state_e;
endpackage

`endif

// File: rtl/ijtc_write_scheduler_if.sv
// ijtc_write_scheduler_if
//   Bundles the lookup, speculative-history, repair and table-RAM signals.
//   slave  : scheduler side (inputs *_i, outputs *_o)
//   master : fetch/back-end/RAM side
//   With IJTC_WR_BYPASS_EN defined, adds lk_byp_valid_o / lk_byp_data_o.
interface ijtc_write_scheduler_if
  import ijtc_write_scheduler_pkg::*;
#(
  parameter int IDX_W = IJTC_IDX_W,
  parameter int GHR_W = IJTC_GHR_W
);
  logic             lk_req_i;
  logic [31:0]      lk_vaddr_i;
  logic             lk_ready_o;
  logic [GHR_W-1:0] lk_ckpt_o;
  logic             spec_valid_i;
  logic             spec_take_i;
  logic             rep_valid_i;
  logic             rep_ready_o;
  logic [GHR_W-1:0] rep_ghr_i;
  logic [31:0]      rep_vaddr_i;
  logic             rep_take_i;
  logic [31:0]      rep_dest_i;
  logic [IDX_W-1:0] ram_raddr_o;
  logic             ram_wen_o;
  logic [IDX_W-1:0] ram_waddr_o;
  logic [31:0]      ram_wdata_o;
`ifdef IJTC_WR_BYPASS_EN
  logic             lk_byp_valid_o;
  logic [31:0]      lk_byp_data_o;
`endif

  modport slave (
    input  lk_req_i, lk_vaddr_i, spec_valid_i, spec_take_i,
    input  rep_valid_i, rep_ghr_i, rep_vaddr_i, rep_take_i, rep_dest_i,
    output lk_ready_o, lk_ckpt_o, rep_ready_o,
    output ram_raddr_o, ram_wen_o, ram_waddr_o, ram_wdata_o
`ifdef IJTC_WR_BYPASS_EN
    , output lk_byp_valid_o, lk_byp_data_o
`endif
  );

  modport master (
    output lk_req_i, lk_vaddr_i, spec_valid_i, spec_take_i,
    output rep_valid_i, rep_ghr_i, rep_vaddr_i, rep_take_i, rep_dest_i,
    input  lk_ready_o, lk_ckpt_o, rep_ready_o,
    input  ram_raddr_o, ram_wen_o, ram_waddr_o, ram_wdata_o
`ifdef IJTC_WR_BYPASS_EN
    , input lk_byp_valid_o, lk_byp_data_o
`endif
  );
endinterface

// File: rtl/ijtc_write_scheduler_repair.sv
// ijtc_repair_fifo
//   Synchronous FIFO holding pending table writes {idx, dest}.
//   Ports: clk, rst (async high), push/push_data, pop, head, full, empty,
//   count (occupancy). With IJTC_WR_BYPASS_EN defined it also exposes every
//   slot ordered by age (ent_*[0] = head) for the lookup bypass.
//   Pointers carry one extra bit so full and empty are distinguishable.
module ijtc_repair_fifo
  import ijtc_write_scheduler_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = IJTC_IDX_W + IJTC_DATA_W
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [W-1:0]              push_data,
  input  logic                      pop,
  output logic [W-1:0]              head,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
`ifdef IJTC_WR_BYPASS_EN
  , output logic [DEPTH-1:0]        ent_vld,
  output logic [DEPTH-1:0][W-1:0]   ent_data
`endif
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr, rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

`ifdef IJTC_WR_BYPASS_EN
  for (genvar k = 0; k < DEPTH; k++) begin : g_ent
    logic [PW-1:0] slot;
    assign slot        = rd_ptr[PW-1:0] + PW'(k);
    assign ent_data[k] = mem[slot];
    assign ent_vld[k]  = ((PW+1)'(k) < count);
  end
`endif
endmodule

// File: rtl/ijtc_write_scheduler.sv
// ijtc_write_scheduler
//   Front-end controller for the IJTC table RAM (1 read + 1 write port).
//   Owns the GHR, hashes lookup/repair indices, queues taken repairs and
//   schedules their writes. Lookups win the write slot except in FORCE,
//   entered when the queue is full or the head has waited STARVE_MAX cycles.
//   Ports: clk, rst (async high), bus (ijtc_write_scheduler_if.slave).
//   Optional: IJTC_WR_BYPASS_EN adds a registered lookup bypass from the
//   pending-write queue (youngest matching entry wins).
module ijtc_write_scheduler
  import ijtc_write_scheduler_pkg::*;
#(
  parameter int IDX_W      = IJTC_IDX_W,
  parameter int GHR_W      = IJTC_GHR_W,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
)(
  input  logic                  clk,
  input  logic                  rst,
  ijtc_write_scheduler_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam int EW = IDX_W + 32;

  sched_state_e     state, state_nxt;
  logic [GHR_W-1:0] ghr, ghr_nxt;
  logic [GHR_W-1:0] ckpt;
  logic [CW-1:0]    starve, starve_nxt;
  logic [IDX_W-1:0] lk_idx, rep_idx;
  logic [EW-1:0]    head;
  logic [PW:0]      fifo_cnt, cnt_nxt;
  logic             fifo_full, fifo_empty;
  logic             lk_ready, lk_acc, rep_acc, push, pop;

  assign lk_idx  = `IJTC_HASH(bus.lk_vaddr_i, ghr, IDX_W);
  assign rep_idx = `IJTC_HASH(bus.rep_vaddr_i, bus.rep_ghr_i, IDX_W);

  // rep_ready comes straight off the registered full flag: no path from pop.
  assign rep_acc = bus.rep_valid_i && !fifo_full;
  assign push    = rep_acc && bus.rep_take_i;
  assign lk_acc  = bus.lk_req_i && lk_ready;
  assign cnt_nxt = fifo_cnt + (PW+1)'(push) - (PW+1)'(pop);

  // Repair overrides any same-cycle speculative shift.
  always_comb begin
    ghr_nxt = ghr;
    if (rep_acc)               ghr_nxt = {bus.rep_ghr_i[GHR_W-2:0], bus.rep_take_i};
    else if (bus.spec_valid_i) ghr_nxt = {ghr[GHR_W-2:0], bus.spec_take_i};
  end

  ijtc_repair_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({rep_idx, bus.rep_dest_i}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
`ifdef IJTC_WR_BYPASS_EN
    , .ent_vld (ent_vld),
    .ent_data  (ent_data)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      starve <= '0;
      ghr    <= '0;
      ckpt   <= '0;
    end else begin
      state  <= state_nxt;
      starve <= starve_nxt;
      ghr    <= ghr_nxt;
      if (lk_acc) ckpt <= ghr;
    end
  end

  // Next state is judged on post-edge occupancy and wait count.
  always_comb begin
    lk_ready   = 1'b1;
    pop        = 1'b0;
    starve_nxt = starve;
    state_nxt  = state;
    unique case (state)
      ST_IDLE:  starve_nxt = '0;
      ST_DRAIN: begin
        if (bus.lk_req_i) begin
          starve_nxt = starve + 1'b1;
        end else if (!fifo_empty) begin
          pop        = 1'b1;
          starve_nxt = '0;
        end
      end
      ST_FORCE: begin
        lk_ready   = 1'b0;
        pop        = !fifo_empty;
        starve_nxt = '0;
      end
      default:  starve_nxt = '0;
    endcase
    if (cnt_nxt == '0)
      state_nxt = ST_IDLE;
    else if (cnt_nxt == (PW+1)'(FIFO_DEPTH) || starve_nxt >= CW'(STARVE_MAX))
      state_nxt = ST_FORCE;
    else
      state_nxt = ST_DRAIN;
  end

  assign bus.lk_ready_o  = lk_ready;
  assign bus.lk_ckpt_o   = ckpt;
  assign bus.rep_ready_o = !fifo_full;
  assign bus.ram_raddr_o = lk_idx;
  assign bus.ram_wen_o   = pop;
  assign bus.ram_waddr_o = pop ? head[EW-1:32] : '0;
  assign bus.ram_wdata_o = pop ? head[31:0]    : '0;

  // PC bits outside the hash window carry no information here.
  logic unused_pc;
  assign unused_pc = ^{bus.lk_vaddr_i[31:IDX_W+2], bus.lk_vaddr_i[1:0],
                       bus.rep_vaddr_i[31:IDX_W+2], bus.rep_vaddr_i[1:0]};

`ifdef IJTC_WR_BYPASS_EN
  logic [FIFO_DEPTH-1:0]        ent_vld;
  logic [FIFO_DEPTH-1:0][EW-1:0] ent_data;
  logic                         byp_hit, byp_valid;
  logic [31:0]                  byp_data, byp_data_q;

  // Scan oldest to youngest so the youngest match is what remains.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      if (ent_vld[k] && ent_data[k][EW-1:32] == lk_idx) begin
        byp_hit  = 1'b1;
        byp_data = ent_data[k][31:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_valid  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_valid <= lk_acc && byp_hit;
      if (lk_acc && byp_hit) byp_data_q <= byp_data;
    end
  end

  assign bus.lk_byp_valid_o = byp_valid;
  assign bus.lk_byp_data_o  = byp_data_q;
`endif
endmodule

// File: tb/tb_ijtc_write_scheduler.sv
// tb_ijtc_write_scheduler
//   Directed + randomized bench for ijtc_write_scheduler (default build).
//   A queue-based reference model predicts every cycle's outputs.
module tb_ijtc_write_scheduler;
  localparam int IDX_W  = 10;
  localparam int GHR_W  = 10;
  localparam int DEPTH  = 4;
  localparam int STARVE = 8;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [31:0]      dest;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ijtc_write_scheduler_if #(.IDX_W(IDX_W), .GHR_W(GHR_W)) bus ();

  ijtc_write_scheduler #(
    .IDX_W(IDX_W), .GHR_W(GHR_W), .FIFO_DEPTH(DEPTH), .STARVE_MAX(STARVE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state
  ent_t             q[$];
  logic [GHR_W-1:0] m_ghr, m_ckpt;
  int               m_wait;
  bit               m_force;

  int   n_cmp = 0, n_bad = 0, n_dut_wr = 0;
  ent_t wr_log[$];

  function automatic logic [IDX_W-1:0] hash(logic [31:0] va, logic [GHR_W-1:0] g);
    logic [31:0] w;
    w = va >> 2;
    return w[IDX_W-1:0] ^ g;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ghr = '0; m_ckpt = '0; m_wait = 0; m_force = 0;
  endtask

  task automatic set_idle();
    bus.lk_req_i = 0; bus.lk_vaddr_i = '0;
    bus.spec_valid_i = 0; bus.spec_take_i = 0;
    bus.rep_valid_i = 0; bus.rep_ghr_i = '0; bus.rep_vaddr_i = '0;
    bus.rep_take_i = 0; bus.rep_dest_i = '0;
  endtask

  task automatic set_rep(logic [GHR_W-1:0] g, logic [31:0] va, logic tk, logic [31:0] d);
    bus.rep_valid_i = 1; bus.rep_ghr_i = g; bus.rep_vaddr_i = va;
    bus.rep_take_i = tk; bus.rep_dest_i = d;
  endtask

  // One clock: check outputs mid-cycle, then advance the model across the edge.
  task automatic cycle();
    bit   wr, racc;
    ent_t e;
    @(negedge clk);
    wr = (q.size() > 0) && (m_force || !bus.lk_req_i);
    chk("lk_ready", bus.lk_ready_o, !m_force);
    chk("rep_ready", bus.rep_ready_o, q.size() < DEPTH);
    chk("wen", bus.ram_wen_o, wr);
    if (wr) begin
      chk("waddr", bus.ram_waddr_o, q[0].idx);
      chk("wdata", bus.ram_wdata_o, q[0].dest);
    end
    if (bus.lk_req_i) chk("raddr", bus.ram_raddr_o, hash(bus.lk_vaddr_i, m_ghr));
    chk("ckpt", bus.lk_ckpt_o, m_ckpt);
    if (bus.ram_wen_o === 1'b1) begin
      n_dut_wr++;
      e.idx = bus.ram_waddr_o; e.dest = bus.ram_wdata_o;
      wr_log.push_back(e);
    end
    @(posedge clk);
    if (bus.lk_req_i && !m_force) m_ckpt = m_ghr;
    racc = bus.rep_valid_i && (q.size() < DEPTH);
    if (wr) begin
      void'(q.pop_front());
      m_wait = 0;
    end else if (q.size() > 0 && bus.lk_req_i) begin
      m_wait++;
    end
    if (racc && bus.rep_take_i) begin
      e.idx = hash(bus.rep_vaddr_i, bus.rep_ghr_i); e.dest = bus.rep_dest_i;
      q.push_back(e);
    end
    if (racc)                  m_ghr = {bus.rep_ghr_i[GHR_W-2:0], bus.rep_take_i};
    else if (bus.spec_valid_i) m_ghr = {m_ghr[GHR_W-2:0], bus.spec_take_i};
    if (q.size() == 0) m_wait = 0;
    m_force = (q.size() > 0) && (q.size() == DEPTH || m_wait >= STARVE);
    #1;
  endtask

  task automatic do_reset(int cycles);
    rst = 1;
    model_reset();
    set_idle();
    repeat (cycles) begin
      @(negedge clk);
      chk("rst_wen", bus.ram_wen_o, 1'b0);
      chk("rst_lk_ready", bus.lk_ready_o, 1'b1);
      chk("rst_rep_ready", bus.rep_ready_o, 1'b1);
      chk("rst_ckpt", bus.lk_ckpt_o, '0);
      chk("rst_waddr", bus.ram_waddr_o, '0);
      chk("rst_wdata", bus.ram_wdata_o, '0);
      chk("rst_raddr", bus.ram_raddr_o, '0);
    end
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    int first_wr, low_cnt, blk_k, guard, base;
    bit acc;
    ent_t exp_q[$];
    ent_t e;

    rst = 1;
    set_idle();
    do_reset(2);

    // Speculative taken x3 while looking up 0x1000
    bus.lk_req_i = 1; bus.lk_vaddr_i = 32'h0000_1000;
    bus.spec_valid_i = 1; bus.spec_take_i = 1;
    repeat (3) cycle();
    bus.spec_valid_i = 0;
    #2 chk("t1_raddr", bus.ram_raddr_o, 10'h007);
    cycle();
    chk("t1_ckpt", bus.lk_ckpt_o, 10'h007);
    set_idle();

    // Single taken repair, no lookups
    set_rep(10'h155, 32'h0000_2008, 1'b1, 32'h0000_3000);
    cycle();
    set_idle();
    #2;
    chk("t2_wen", bus.ram_wen_o, 1'b1);
    chk("t2_waddr", bus.ram_waddr_o, 10'h002 ^ 10'h155);
    chk("t2_wdata", bus.ram_wdata_o, 32'h0000_3000);
    cycle();
    bus.lk_req_i = 1; bus.lk_vaddr_i = '0;
    #2 chk("t2_ghr", bus.ram_raddr_o, 10'h2AB);
    cycle();
    set_idle();

    // Not-taken repair: history only
    base = n_dut_wr;
    set_rep(10'h3C3, 32'h0000_4444, 1'b0, 32'hDEAD_BEEF);
    cycle();
    set_idle();
    repeat (12) cycle();
    chk("t3_nowrite", n_dut_wr - base, 0);
    bus.lk_req_i = 1;
    #2 chk("t3_ghr", bus.ram_raddr_o, 10'h386);
    cycle();

    // Starvation guard: one entry under continuous lookups
    set_rep(10'h011, 32'h0000_0100, 1'b1, 32'h0000_5555);
    cycle();
    bus.rep_valid_i = 0;
    first_wr = 0; low_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      #2;
      if (bus.ram_wen_o === 1'b1 && first_wr == 0) first_wr = i;
      if (bus.lk_ready_o !== 1'b1) low_cnt++;
      cycle();
    end
    chk("t4_first_wr", first_wr, STARVE + 1);
    chk("t4_stall_cycles", low_cnt, 1);

    // Five taken repairs back-to-back under continuous lookups
    wr_log.delete();
    exp_q.delete();
    blk_k = -1;
    for (int k = 0; k < 5; k++) begin
      set_rep(10'(k * 37), 32'h0000_0040 + 32'(k * 4), 1'b1, 32'hA000_0000 + 32'(k));
      e.idx = hash(bus.rep_vaddr_i, bus.rep_ghr_i); e.dest = bus.rep_dest_i;
      exp_q.push_back(e);
      guard = 0;
      do begin
        #2 acc = bus.rep_ready_o;
        if (!acc && blk_k < 0) blk_k = k;
        cycle();
        guard++;
      end while (!acc && guard < 50);
      chk("t5_accept_bound", guard < 50, 1'b1);
    end
    bus.rep_valid_i = 0;
    chk("t5_block_at", blk_k, 4);
    repeat (45) cycle();
    bus.lk_req_i = 0;
    repeat (10) cycle();
    chk("t5_wr_count", wr_log.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < wr_log.size()) chk("t5_wr_order", wr_log[k], exp_q[k]);

    // Repair and speculative update in the same cycle
    set_rep(10'h0F0, 32'h0000_0008, 1'b0, 32'h0);
    bus.spec_valid_i = 1; bus.spec_take_i = 1;
    cycle();
    set_idle();
    bus.lk_req_i = 1;
    #2 chk("t6_ghr", bus.ram_raddr_o, 10'h1E0);
    cycle();

    // Reset with three entries queued flushes them
    for (int k = 0; k < 3; k++) begin
      set_rep(10'(k + 1), 32'h0000_0800 + 32'(k * 4), 1'b1, 32'hC000_0000 + 32'(k));
      cycle();
    end
    chk("t7_queued", q.size(), 3);
    do_reset(2);
    base = n_dut_wr;
    repeat (20) cycle();
    chk("t7_no_write", n_dut_wr - base, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.lk_req_i     = ($urandom_range(0, 3) != 0);
      bus.lk_vaddr_i   = $urandom();
      bus.spec_valid_i = $urandom_range(0, 1);
      bus.spec_take_i  = $urandom_range(0, 1);
      bus.rep_valid_i  = ($urandom_range(0, 2) == 0);
      bus.rep_ghr_i    = GHR_W'($urandom());
      bus.rep_vaddr_i  = $urandom();
      bus.rep_take_i   = ($urandom_range(0, 3) != 0);
      bus.rep_dest_i   = $urandom();
      cycle();
    end
    set_idle();
    repeat (10) cycle();
    chk("final_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
